// File: rtl/lfsr_pkg.sv
// Shared constants and next-state function for the 4-bit Fibonacci LFSR.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 4;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 4'b0001;

  typedef logic [LFSR_W-1:0] lfsr_state_t;

  // Taps x^4 + x^3 + 1 in right-shift form: feedback enters the MSB.
  function automatic lfsr_state_t lfsr_next(input lfsr_state_t state);
    return {state[1] ^ state[0], state[3:1]};
  endfunction

endpackage

// File: rtl/lfsr4.sv
// Free-running 4-bit maximal-length LFSR; period 15 from any non-zero state.
module lfsr4
  import lfsr_pkg::*;
#(
  parameter logic [3:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] data_out
);

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr4: SEED must be non-zero");
  end

  lfsr_state_t s_q;
  lfsr_state_t s_d;

  // An all-zero state is a fixed point of the shift, so it reloads SEED.
  always_comb begin
    s_d = lfsr_next(s_q);
    if (reset || (s_q == '0)) begin
      s_d = SEED;
    end
  end

  always_ff @(posedge clk) begin
    s_q <= s_d;
  end

  assign data_out = s_q;

endmodule

// File: tb/tb_lfsr4.sv
// Directed self-checking bench for lfsr4: sequence, period, reset, lock-up, seed override.
module tb_lfsr4;
  import lfsr_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data_out;
  logic [3:0] data_out_s;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  lfsr4 dut (
    .clk      (clk),
    .reset    (reset),
    .data_out (data_out)
  );

  lfsr4 #(.SEED(4'b1010)) u_seed (
    .clk      (clk),
    .reset    (reset),
    .data_out (data_out_s)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] seq_exp [15] = '{4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100,
                                4'b0110, 4'b1011, 4'b0101, 4'b1010, 4'b1101,
                                4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
  logic [3:0] seed_exp [3]  = '{4'b1101, 4'b1110, 4'b1111};

  initial begin
    logic [3:0]  prev;
    logic [15:0] seen;
    int unsigned n_seed_hits;
    int unsigned n_zero;
    int unsigned n_distinct;

    // Reset held for two edges
    reset = 1'b1;
    tick();
    check_eq("reset_edge1", data_out, 4'b0001);
    tick();
    check_eq("reset_edge2", data_out, 4'b0001);

    // One full period against the hand table and the reference function
    reset = 1'b0;
    prev  = data_out;
    for (int i = 0; i < 15; i++) begin
      tick();
      check_eq($sformatf("seq_tbl[%0d]", i), data_out, seq_exp[i]);
      check_eq($sformatf("seq_ref[%0d]", i), data_out, lfsr_next(prev));
      prev = data_out;
    end

    // Three more periods: recurrence, coverage, no zero state
    seen        = '0;
    n_seed_hits = 0;
    n_zero      = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (data_out == 4'b0001) n_seed_hits++;
      if (data_out == 4'b0000) n_zero++;
      if (!$isunknown(data_out)) seen[data_out] = 1'b1;
      if ((i % 15) == 14) check_eq($sformatf("period_seed[%0d]", i), data_out, 4'b0001);
    end
    n_distinct = 0;
    for (int b = 0; b < 16; b++) if (seen[b]) n_distinct++;
    check_eq("period_hits", n_seed_hits, 3);
    check_eq("distinct", n_distinct, 15);
    check_eq("zero_seen", n_zero, 0);

    // Mid-run reset after 7 edges
    for (int i = 0; i < 7; i++) tick();
    check_eq("mid_pre", data_out, 4'b1011);
    reset = 1'b1;
    tick();
    check_eq("mid_reset", data_out, 4'b0001);
    reset = 1'b0;
    tick();
    check_eq("mid_resume", data_out, 4'b1000);

    // Lock-up recovery from a planted all-zero state
    force dut.s_q = 4'b0000;
    #1;
    release dut.s_q;
    #1;
    check_eq("lock_zero", data_out, 4'b0000);
    tick();
    check_eq("lock_reload", data_out, 4'b0001);
    tick();
    check_eq("lock_next", data_out, 4'b1000);

    // Seed override instance
    reset = 1'b1;
    tick();
    check_eq("seed_reset", data_out_s, 4'b1010);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("seed_seq[%0d]", i), data_out_s, seed_exp[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
